gf_table_engine: RTL and testbench

Self-initialising, parametrised GF(2^M) conversion table for the Reed-Solomon decoder datapath. After reset it generates both the power-to-decimal (antilog) and decimal-to-power (log) tables from a primitive polynomial with an LFSR state machine, instead of relying on a fixed 8-bit ROM image. It then serves NUM_CH independent registered read ports, each selecting either conversion direction per access. Syndrome, Chien and Forney stages share one instance instead of each holding its own ROM copy.

---
 rtl/gf_pkg.sv | 14 +
 rtl/gf_lfsr_gen.sv | 85 ++++++++
 rtl/gf_table_engine.sv | 71 +++++++
 tb/tb_gf_table_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared constants and the generator state encoding for the GF(2^M) table engine.
package gf_pkg;

  localparam int         GF_M         = 8;
  localparam logic [7:0] GF_PRIM_POLY = 8'h1D;
  localparam int         GF_DEPTH     = 1 << GF_M;

  typedef enum logic [1:0] {
    GEN_CLR = 2'd0,
    GEN_RUN = 2'd1,
    READY   = 2'd2
  } gen_state_t;

endpackage

// File: rtl/gf_lfsr_gen.sv
// Table generator: steps alpha^k through the field with an LFSR and emits
// one (power code, decimal value) pair per cycle for both tables.
//
// state   | meaning
// --------+-----------------------------------------------------------
// GEN_CLR | write the zero element pair (0,0); seed a=1, k=0
// GEN_RUN | write pair (k+1, a); advance a by multiply-by-x; k++
// READY   | tables valid; a rebuild request reloads poly and restarts
module gf_lfsr_gen
  import gf_pkg::*;
#(
  parameter int         M         = GF_M,
  parameter logic [M-1:0] PRIM_POLY = M'(GF_PRIM_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rebuild_req,
  input  logic [M-1:0] poly_in,
  output logic         ready,
  output logic         poly_err,
  output logic         wr_en,
  output logic [M-1:0] wr_pow,
  output logic [M-1:0] wr_dec
);

  localparam logic [M-1:0] K_LAST = M'((1 << M) - 2);

  gen_state_t   state;
  logic [M-1:0] poly;
  logic [M-1:0] a;
  logic [M-1:0] k;
  logic [M-1:0] a_next;

  always_comb begin
    a_next = {a[M-2:0], 1'b0} ^ (a[M-1] ? poly : '0);
  end

  // Write port is decoded from the current state so the last entry lands on
  // the same edge that raises ready.
  assign wr_en  = (state != READY);
  assign wr_pow = (state == GEN_RUN) ? k + 1'b1 : '0;
  assign wr_dec = (state == GEN_RUN) ? a : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GEN_CLR;
      poly     <= PRIM_POLY;
      a        <= M'(1);
      k        <= '0;
      ready    <= 1'b0;
      poly_err <= 1'b0;
    end else begin
      case (state)
        GEN_CLR: begin
          a     <= M'(1);
          k     <= '0;
          state <= GEN_RUN;
        end
        GEN_RUN: begin
          a <= a_next;
          k <= k + 1'b1;
          // Returning to 1 before the full cycle means the order of x is short.
          if (a_next == M'(1) && k != K_LAST) poly_err <= 1'b1;
          if (k == K_LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (rebuild_req) begin
            poly     <= poly_in;
            poly_err <= 1'b0;
            ready    <= 1'b0;
            state    <= GEN_CLR;
          end
        end
        default: begin
          state <= GEN_CLR;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gf_table_engine.sv
// Self-initialising GF(2^M) antilog/log tables with NUM_CH independent
// registered read ports shared by the Reed-Solomon decoder stages.
module gf_table_engine
  import gf_pkg::*;
#(
  parameter int           M         = GF_M,
  parameter logic [M-1:0] PRIM_POLY = M'(GF_PRIM_POLY),
  parameter int           NUM_CH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rebuild_req,
  input  logic [M-1:0]        poly_in,
  output logic                ready,
  output logic                poly_err,
  input  logic [NUM_CH-1:0]   re,
  input  logic [NUM_CH-1:0]   mode,
  input  logic [NUM_CH*M-1:0] addr,
  output logic [NUM_CH*M-1:0] dout,
  output logic [NUM_CH-1:0]   dout_valid
);

  localparam int DEPTH = 1 << M;

  logic         wr_en;
  logic [M-1:0] wr_pow;
  logic [M-1:0] wr_dec;

  logic [M-1:0] exp_mem [DEPTH];
  logic [M-1:0] log_mem [DEPTH];

  gf_lfsr_gen #(
    .M         (M),
    .PRIM_POLY (PRIM_POLY)
  ) u_gen (
    .clk         (clk),
    .rst_n       (reset),
    .rebuild_req (rebuild_req),
    .poly_in     (poly_in),
    .ready       (ready),
    .poly_err    (poly_err),
    .wr_en       (wr_en),
    .wr_pow      (wr_pow),
    .wr_dec      (wr_dec)
  );

  // Arrays are intentionally not reset; every entry is rewritten by generation.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      exp_mem[wr_pow] <= wr_dec;
      log_mem[wr_dec] <= wr_pow;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ready && re[c]) begin
          dout[c*M +: M] <= mode[c] ? log_mem[addr[c*M +: M]] : exp_mem[addr[c*M +: M]];
          dout_valid[c]  <= 1'b1;
        end else begin
          dout_valid[c]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf_table_engine.sv
// Directed bench for gf_table_engine: scoreboarded reads, generation timing,
// rebuild behaviour and asynchronous reset.
module tb_gf_table_engine;

  localparam int M   = 8;
  localparam int NCH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rebuild_req = 1'b0;
  logic [M-1:0]     poly_in = '0;
  logic             ready;
  logic             poly_err;
  logic [NCH-1:0]   re = '0;
  logic [NCH-1:0]   mode = '0;
  logic [NCH*M-1:0] addr = '0;
  logic [NCH*M-1:0] dout;
  logic [NCH-1:0]   dout_valid;

  always #5 clk = ~clk;

  gf_table_engine dut (
    .clk         (clk),
    .reset       (rst_n),
    .rebuild_req (rebuild_req),
    .poly_in     (poly_in),
    .ready       (ready),
    .poly_err    (poly_err),
    .re          (re),
    .mode        (mode),
    .addr        (addr),
    .dout        (dout),
    .dout_valid  (dout_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int           ch;
    logic [M-1:0] val;
    string        tag;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks = n_checks + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input int ch, input bit md, input logic [M-1:0] a,
                            input logic [M-1:0] v, input string tag);
    exp_t e;
    re[ch]            = 1'b1;
    mode[ch]          = md;
    addr[ch*M +: M]   = a;
    e.ch  = ch;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    cycle();
    re = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_valid"}, 32'(dout_valid[e.ch]), 32'd1);
      check(e.tag, 32'(dout[e.ch*M +: M]), 32'(e.val));
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      cycle();
      n = n + 1;
    end while (!ready && n < 400);
  endtask

  task automatic single_read(input int ch, input bit md, input logic [M-1:0] a,
                             input logic [M-1:0] v, input string tag);
    drive_read(ch, md, a, v, tag);
    collect();
  endtask

  int edges;
  int n;

  initial begin
    #2;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_poly_err", 32'(poly_err), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);

    #20 rst_n = 1'b1;
    edges = 0;

    // Reads before the tables are ready must be ignored.
    re   = 2'b11;
    addr = {8'd9, 8'd9};
    repeat (3) begin
      cycle();
      edges = edges + 1;
      check("early_valid", 32'(dout_valid), 32'd0);
      check("early_dout", 32'(dout), 32'd0);
    end
    re = '0;
    wait_ready(n);
    check("ready_lat_reset", 32'(edges + n), 32'd256);
    check("poly_err_default", 32'(poly_err), 32'd0);

    single_read(0, 1'b0, 8'h00, 8'h00, "exp_0");
    single_read(0, 1'b0, 8'h01, 8'h01, "exp_1");
    single_read(0, 1'b0, 8'h09, 8'h1D, "exp_9");
    cycle();
    check("hold_dout", 32'(dout[7:0]), 32'h1D);
    check("hold_valid", 32'(dout_valid), 32'd0);
    single_read(1, 1'b0, 8'hFF, 8'h8E, "exp_255");
    single_read(0, 1'b1, 8'h1D, 8'd9, "log_1d");
    single_read(1, 1'b1, 8'h8E, 8'd255, "log_8e");
    single_read(1, 1'b1, 8'h00, 8'h00, "log_0");

    drive_read(0, 1'b0, 8'd26, 8'h03, "dual_ch0");
    drive_read(1, 1'b1, 8'h03, 8'd26, "dual_ch1");
    collect();

    // Rebuild with 0x2D while a read is in flight; the read sees the old table.
    drive_read(0, 1'b0, 8'd9, 8'h1D, "rb_old_read");
    rebuild_req = 1'b1;
    poly_in     = 8'h2D;
    collect();
    rebuild_req = 1'b0;
    check("rb_ready_fall", 32'(ready), 32'd0);

    repeat (3) cycle();
    rebuild_req = 1'b1;
    poly_in     = 8'h1B;
    cycle();
    rebuild_req = 1'b0;
    repeat (6) cycle();
    edges = 10;
    wait_ready(n);
    check("ready_lat_2d", 32'(edges + n), 32'd256);
    check("poly_err_2d", 32'(poly_err), 32'd0);
    drive_read(0, 1'b0, 8'd9, 8'h2D, "exp9_2d");
    drive_read(1, 1'b1, 8'h2D, 8'd9, "log2d_2d");
    collect();

    // 0x11B is irreducible but x has order 51.
    drive_read(0, 1'b0, 8'd9, 8'h2D, "rb2_old_read");
    rebuild_req = 1'b1;
    poly_in     = 8'h1B;
    collect();
    rebuild_req = 1'b0;
    wait_ready(n);
    check("ready_lat_1b", 32'(n), 32'd256);
    check("poly_err_1b", 32'(poly_err), 32'd1);

    rebuild_req = 1'b1;
    cycle();
    rebuild_req = 1'b0;
    check("err_cleared_on_rebuild", 32'(poly_err), 32'd0);
    check("ready_low_rebuild", 32'(ready), 32'd0);
    repeat (99) cycle();
    check("err_midgen", 32'(poly_err), 32'd1);

    #2 rst_n = 1'b0;
    #1;
    check("async_ready", 32'(ready), 32'd0);
    check("async_poly_err", 32'(poly_err), 32'd0);
    check("async_dout", 32'(dout), 32'd0);
    check("async_valid", 32'(dout_valid), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    check("ready_lat_rst2", 32'(n), 32'd256);
    check("poly_err_rst2", 32'(poly_err), 32'd0);
    single_read(0, 1'b0, 8'd9, 8'h1D, "exp9_rst2");
    single_read(1, 1'b1, 8'h03, 8'd26, "log3_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
